// File: rtl/gate_sweep_checker_pkg.sv
// Shared definitions for the gate sweep checker: FSM state encoding and
// the width of the settle-delay counter.
package gate_sweep_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int SETTLE_CW = 4;

endpackage

// File: rtl/gate_ref_model.sv
// Golden AND/OR reference for the gate unit. It is purely combinational, so
// benches can instantiate it on its own.
module gate_ref_model #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] w
);

  assign z = a & b;
  assign w = a | b;

endmodule

// File: rtl/gate_sweep_checker.sv
// BIST sweep engine: drives every {a,b} operand pair into the AND/OR gate,
// compares the results against gate_ref_model and counts mismatches.
module gate_sweep_checker
  import gate_sweep_defs::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  input  logic [WIDTH-1:0]     z_i,
  input  logic [WIDTH-1:0]     w_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic                 first_err_valid,
  output logic [2*WIDTH-1:0]   first_err_vec
);

  localparam int VW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;
  localparam logic [SETTLE_CW-1:0] SETTLE_LOAD =
    (SETTLE == 0) ? '0 : SETTLE_CW'(SETTLE - 1);
  localparam state_e ENTRY_STATE = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;

  state_e                 state_q, state_d;
  logic [VW-1:0]          vec_q, vec_d;
  logic [SETTLE_CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]          err_q, err_d;
  logic                   fev_q, fev_d;
  logic [VW-1:0]          fvec_q, fvec_d;

  logic [WIDTH-1:0]       exp_z, exp_w;
  logic                   mismatch;

  assign a_o = vec_q[VW-1:WIDTH];
  assign b_o = vec_q[WIDTH-1:0];

  gate_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a (a_o),
    .b (b_o),
    .z (exp_z),
    .w (exp_w)
  );

  // NOTE: case inequality is deliberate: an X or Z result from the gate must be
  // reported as a failure, not silently treated as a match.
  assign mismatch = (z_i !== exp_z) || (w_i !== exp_w);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fvec_d  = fvec_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fvec_d  = '0;
          cnt_d   = SETTLE_LOAD;
          state_d = ENTRY_STATE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CHECK;
        else             cnt_d   = cnt_q - SETTLE_CW'(1);
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + EW'(1);
          if (!fev_q) begin
            fev_d  = 1'b1;
            fvec_d = vec_q;
          end
        end
        // The last vector goes to DONE, so vec never wraps past all-ones.
        if (vec_q == '1) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + VW'(1);
          cnt_d   = SETTLE_LOAD;
          state_d = ENTRY_STATE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fvec_q  <= fvec_d;
    end
  end

  assign busy            = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done            = (state_q == ST_DONE);
  assign pass            = done && (err_q == '0);
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fvec_q;

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Self-checking sweep engine that wraps the 2-input AND/OR gate unit (z = a & b, w = a | b).
- Upstream, it drives every a/b operand combination into the gate.
- Downstream, it samples the z/w results, compares them against a built-in reference, and counts mismatches.
- It replaces hand-written exhaustive stimulus in benches and serves as the on-chip built-in self-test (BIST) for the gate.

Parameters:
- WIDTH, 1, bit width of each operand a/b and of each result z/w (the gate is applied bitwise).
- SETTLE, 1, number of wait cycles between driving a vector and sampling results; range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE.
- a_o  output  WIDTH  operand a driven to the gate unit.
- b_o  output  WIDTH  operand b driven to the gate unit.
- z_i  input  WIDTH  gate AND result.
- w_i  input  WIDTH  gate OR result.
- busy  output  1  high while a sweep is in progress (SETTLE or CHECK).
- done  output  1  high in DONE; held until the next start or rst.
- pass  output  1  equals done AND (err_count == 0).
- err_count  output  2*WIDTH+1  number of mismatching vectors in the last sweep; saturates at all-ones.
- first_err_valid  output  1  high once any mismatch has been recorded in the current sweep.
- first_err_vec  output  2*WIDTH  {a,b} of the first mismatching vector.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high: every flop is cleared immediately on rst, independent of clk.
- Reset values: state=IDLE, vector counter=0, a_o=0, b_o=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0.
- Operand mapping: the vector counter vec is 2*WIDTH bits wide, with a_o = vec[2W-1:W] and b_o = vec[W-1:0]. For WIDTH=1 the sweep order is (a,b) = 00, 01, 10, 11.
- Expected results: exp_z = a_o & b_o and exp_w = a_o | b_o, bitwise.
- States:
  - IDLE: outputs static. start=1 -> vec=0, cleared err_count, first_err_valid and first_err_vec, settle counter=SETTLE-1; go to SETTLE, or directly to CHECK if SETTLE=0.
  - SETTLE: operands held stable. Counter==0 -> CHECK; otherwise decrement. Dwell is exactly SETTLE cycles.
  - CHECK: one cycle. Sample z_i and w_i and compare with the expected values using case inequality, so X or Z on z_i/w_i counts as a mismatch.
    - On mismatch: err_count+1 (saturating). If first_err_valid=0, capture first_err_vec=vec and set first_err_valid=1.
    - If vec is all-ones -> DONE. Otherwise vec+1 and return to SETTLE, or stay in CHECK if SETTLE=0.
  - DONE: done=1, pass valid, a_o/b_o hold the last vector. start=1 -> restart exactly as from IDLE, and done drops on that edge.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - If start is sampled at edge E0, done rises at edge E0 + 2^(2W) * (SETTLE+1).
  - Example: WIDTH=1, SETTLE=1 gives done at E0+8.
- busy and done are registered (state-decoded) and are never high together.
- start while busy is ignored; there is no queuing.
- The counter wrap on vec+1 past all-ones never occurs, because the transition to DONE takes precedence.
- rst asserted mid-sweep aborts immediately to the reset values. No partial result is retained.

Decomposition:
- Shared header/package gate_sweep_defs: state encodings (IDLE, SETTLE, CHECK, DONE, 2-bit) and the SETTLE counter width constant (4).
- Sub-module gate_ref_model: purely combinational expected z/w from a/b, parameterised by WIDTH. The checker instantiates it so that the reference logic is reused by benches.

Test Plan:
- Good gate, WIDTH=1, SETTLE=1, pulse start -> done at start edge + 8 cycles; pass=1; err_count=0; first_err_valid=0; a_o/b_o sequence 00, 01, 10, 11.
- Faulty gate with z stuck-at-0 -> done after 8 cycles; pass=0; err_count=1; first_err_vec=2'b11; first_err_valid=1.
- Faulty gate with w=a&b -> err_count=2; first_err_vec=2'b01.
- start pulsed again at cycle 3 of a sweep -> ignored; done still at E0+8.
- rst asserted in CHECK of vector 2 -> all outputs return to zero asynchronously; a later start runs a complete fresh sweep.
- SETTLE=0, WIDTH=2, good gate -> done at E0+16; pass=1. Then restart from DONE -> done drops for one sweep and rises again 16 cycles later.
